// File: rtl/dct_wave_scheduler_if.sv
// ----------------------------------------------------------------------------
// dct_wave_scheduler_if
//   Bundles the sample stream input, frame-sync gate and wave output of the
//   DCT wave scheduler into one interface.
//
//   Signals:
//     s_valid / s_ready / s_data / s_last : serial sample stream in
//     start_en                            : permits wave launch (frame sync)
//     m_data  [ROW*DATA_WIDTH]            : lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//     m_valid [ROW]                       : per-lane valid to the DCT rows
//     wave_start                          : pulse with word 0 of each wave
//     busy                                : issuing or any bank full
//     err_last                            : s_last seen mid-vector
//
//   Modports:
//     master : stream source / wave sink (testbench or upstream logic)
//     slave  : the scheduler itself
// ----------------------------------------------------------------------------
interface dct_wave_scheduler_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ROW        = 3
);

  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_WIDTH-1:0]     s_data;
  logic                      s_last;
  logic                      start_en;
  logic [ROW*DATA_WIDTH-1:0] m_data;
  logic [ROW-1:0]            m_valid;
  logic                      wave_start;
  logic                      busy;
  logic                      err_last;

  modport master (
    output s_valid, s_data, s_last, start_en,
    input  s_ready, m_data, m_valid, wave_start, busy, err_last
  );

  modport slave (
    input  s_valid, s_data, s_last, start_en,
    output s_ready, m_data, m_valid, wave_start, busy, err_last
  );

endinterface

// File: rtl/dct_wave_scheduler.sv
// ----------------------------------------------------------------------------
// dct_wave_scheduler
//   Collects a serial stream of N-sample vectors into ping-pong banks of ROW
//   vectors and launches each full bank as an aligned wave: all ROW lanes are
//   driven on the same N consecutive cycles so the DCT row array keeps its
//   per-lane skew and modulo-N phase counters aligned. One bank fills while
//   the other issues; back-to-back waves run without a bubble.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous, active-low reset
//     sched  : dct_wave_scheduler_if.slave (stream in, wave out, status)
//
//   Parameters:
//     DATA_WIDTH : sample width
//     ROW        : DCT lanes = vectors per wave
//     N          : samples per vector, power of two >= 2
//
//   Build option:
//     DCT_SCHED_ZERO_PAD_EN : when defined, unused lanes of a short wave
//                             drive m_valid=1 with zero data instead of
//                             m_valid=0.
// ----------------------------------------------------------------------------
module dct_wave_scheduler #(
  parameter int DATA_WIDTH = 10,
  parameter int ROW        = 3,
  parameter int N          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dct_wave_scheduler_if.slave sched
);

  localparam int IDX_W  = $clog2(N);
  localparam int LANE_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int LU_W   = $clog2(ROW + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(ROW - 1);

`ifdef DCT_SCHED_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  // Storage and write-side state
  logic [DATA_WIDTH-1:0] r_mem [2][ROW][N];
  logic [1:0]            r_full;
  logic [LU_W-1:0]       r_lanesUsed [2];
  logic                  r_wrBank;
  logic [LANE_W-1:0]     r_wrLane;
  logic [IDX_W-1:0]      r_wrIdx;
  logic                  r_errLast;

  // Read-side state
  state_t                r_state;
  state_t                w_stateNext;
  logic                  r_rdBank;
  logic                  w_rdBankNext;
  logic [IDX_W-1:0]      r_rdIdx;
  logic [IDX_W-1:0]      w_rdIdxNext;
  logic [IDX_W-1:0]      w_rdIdxInc;

  // Output word staging
  logic                      w_load;
  logic                      w_waveStart;
  logic                      w_release;
  logic [IDX_W-1:0]          w_loadIdx;
  logic [ROW*DATA_WIDTH-1:0] w_loadData;
  logic [ROW-1:0]            w_loadValid;
  logic [ROW*DATA_WIDTH-1:0] r_mData;
  logic [ROW-1:0]            r_mValid;
  logic                      r_waveStart;

  logic w_accept;
  logic w_idxWrap;
  logic w_wrClose;

  // s_ready comes only from the registered full flag, so a bank released on
  // this edge becomes writable on the next cycle, never the same one.
  assign sched.s_ready = ~r_full[r_wrBank];
  assign w_accept      = sched.s_valid & ~r_full[r_wrBank];
  assign w_idxWrap     = (r_wrIdx == IDX_LAST);
  assign w_wrClose     = w_accept & w_idxWrap & ((r_wrLane == LANE_LAST) | sched.s_last);
  assign w_rdIdxInc    = r_rdIdx + 1'b1;

  // Sample storage; contents need no reset because lanes_used gates every read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wrBank][r_wrLane][r_wrIdx] <= sched.s_data;
    end
  end

  // Write pointers, bank full flags and lane counts. The read side only ever
  // releases the bank it is issuing, which is full and therefore never the
  // bank being written, so set and clear cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrBank       <= 1'b0;
      r_wrLane       <= '0;
      r_wrIdx        <= '0;
      r_full         <= '0;
      r_lanesUsed[0] <= '0;
      r_lanesUsed[1] <= '0;
      r_errLast      <= 1'b0;
    end else begin
      r_errLast <= w_accept & sched.s_last & ~w_idxWrap;
      if (w_release) begin
        r_full[r_rdBank] <= 1'b0;
      end
      if (w_accept) begin
        if (w_wrClose) begin
          r_full[r_wrBank]      <= 1'b1;
          r_lanesUsed[r_wrBank] <= LU_W'(r_wrLane) + 1'b1;
          r_wrBank              <= ~r_wrBank;
          r_wrLane              <= '0;
          r_wrIdx               <= '0;
        end else if (w_idxWrap) begin
          r_wrLane <= r_wrLane + 1'b1;
          r_wrIdx  <= '0;
        end else begin
          r_wrIdx <= r_wrIdx + 1'b1;
        end
      end
    end
  end

  // Read FSM next state. r_rdIdx is the word currently on the outputs; the
  // edge loading word N-1 releases the bank and flips r_rdBank so the next
  // boundary can chain straight into word 0 of the other bank.
  always_comb begin
    w_stateNext  = r_state;
    w_rdBankNext = r_rdBank;
    w_rdIdxNext  = r_rdIdx;
    w_load       = 1'b0;
    w_loadIdx    = '0;
    w_waveStart  = 1'b0;
    w_release    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_full[r_rdBank] && sched.start_en) begin
          w_stateNext = ISSUE;
          w_load      = 1'b1;
          w_waveStart = 1'b1;
          w_rdIdxNext = '0;
        end
      end
      ISSUE: begin
        if (r_rdIdx != IDX_LAST) begin
          w_load      = 1'b1;
          w_loadIdx   = w_rdIdxInc;
          w_rdIdxNext = w_rdIdxInc;
          if (w_rdIdxInc == IDX_LAST) begin
            w_release    = 1'b1;
            w_rdBankNext = ~r_rdBank;
          end
        end else if (r_full[r_rdBank] && sched.start_en) begin
          w_load      = 1'b1;
          w_waveStart = 1'b1;
          w_rdIdxNext = '0;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Gather one word per lane; lanes beyond lanes_used always carry zero data.
  always_comb begin
    w_loadData  = '0;
    w_loadValid = '0;
    for (int r = 0; r < ROW; r++) begin
      if (LU_W'(r) < r_lanesUsed[r_rdBank]) begin
        w_loadData[r*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rdBank][r][w_loadIdx];
        w_loadValid[r] = 1'b1;
      end else begin
        w_loadValid[r] = ZERO_PAD;
      end
    end
  end

  // FSM state and registered wave outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rdBank    <= 1'b0;
      r_rdIdx     <= '0;
      r_mData     <= '0;
      r_mValid    <= '0;
      r_waveStart <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_rdBank    <= w_rdBankNext;
      r_rdIdx     <= w_rdIdxNext;
      r_waveStart <= w_waveStart;
      if (w_load) begin
        r_mData  <= w_loadData;
        r_mValid <= w_loadValid;
      end else begin
        r_mData  <= '0;
        r_mValid <= '0;
      end
    end
  end

  assign sched.m_data     = r_mData;
  assign sched.m_valid    = r_mValid;
  assign sched.wave_start = r_waveStart;
  assign sched.err_last   = r_errLast;
  assign sched.busy       = (r_state == ISSUE) | (|r_full);

endmodule

// File: tb/tb_dct_wave_scheduler.sv
// ----------------------------------------------------------------------------
// tb_dct_wave_scheduler
//   Directed testbench for dct_wave_scheduler (DATA_WIDTH=10, ROW=3, N=8).
//   Streams hand-chosen sample ranges, captures every cycle with a non-zero
//   m_valid, and compares the captured waves against expected lane contents,
//   valid masks, wave_start placement and issue cycles.
// ----------------------------------------------------------------------------
module tb_dct_wave_scheduler;

  localparam int DW   = 10;
  localparam int ROWS = 3;
  localparam int NS   = 8;

`ifdef DCT_SCHED_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int cycle      = 0;
  int passCount  = 0;
  int totalCount = 0;
  int failCount  = 0;
  int errHigh    = 0;

  logic [ROWS*DW-1:0] capData  [$];
  logic [ROWS-1:0]    capValid [$];
  logic               capStart [$];
  int                 capCycle [$];

  dct_wave_scheduler_if #(.DATA_WIDTH(DW), .ROW(ROWS)) sched ();

  dct_wave_scheduler #(
    .DATA_WIDTH (DW),
    .ROW        (ROWS),
    .N          (NS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (sched)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Wave capture and err_last pulse counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sched.m_valid != '0) begin
        capData.push_back(sched.m_data);
        capValid.push_back(sched.m_valid);
        capStart.push_back(sched.wave_start);
        capCycle.push_back(cycle);
      end
      if (sched.err_last) errHigh++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Streams count samples first..first+count-1, s_last on index lastAt.
  // Called at a negedge; returns at the negedge after the final transfer.
  task automatic applyStimulus(input int first, input int count, input int lastAt,
                               output int stalls, output int lastCycle);
    logic ok;
    int   waitCnt;
    stalls    = 0;
    lastCycle = -1;
    for (int i = 0; i < count; i++) begin
      sched.s_valid = 1'b1;
      sched.s_data  = DW'(first + i);
      sched.s_last  = (i == lastAt);
      ok      = 1'b0;
      waitCnt = 0;
      while (!ok && waitCnt < 40) begin
        ok = sched.s_ready;
        @(negedge clk);
        if (!ok) begin
          stalls++;
          waitCnt++;
        end
      end
      if (!ok) begin
        checkOutput("stream_accept", 64'(ok), 64'd1);
        break;
      end
      lastCycle = cycle;
    end
    sched.s_valid = 1'b0;
    sched.s_last  = 1'b0;
  endtask

  task automatic clearCapture();
    capData.delete();
    capValid.delete();
    capStart.delete();
    capCycle.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    sched.s_valid = 1'b0;
    sched.s_last  = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Compares NS captured words from queue position q against one wave:
  // lane r holds bases[r]+k when used[r], otherwise zero.
  task automatic checkWave(input string tag, input int q, input int b0, input int b1,
                           input int b2, input logic [2:0] used, input int cyc0);
    int                 bases [3];
    logic [ROWS*DW-1:0] expData;
    logic [2:0]         expValid;
    bases    = '{b0, b1, b2};
    expValid = ZERO_PAD ? 3'b111 : used;
    for (int k = 0; k < NS; k++) begin
      if (q + k < capValid.size()) begin
        expData = '0;
        for (int r = 0; r < ROWS; r++) begin
          if (used[r]) expData[r*DW +: DW] = DW'(bases[r] + k);
        end
        checkOutput($sformatf("%s_valid%0d", tag, k), 64'(capValid[q+k]), 64'(expValid));
        checkOutput($sformatf("%s_data%0d", tag, k), 64'(capData[q+k]), 64'(expData));
        checkOutput($sformatf("%s_start%0d", tag, k), 64'(capStart[q+k]), 64'(k == 0));
        checkOutput($sformatf("%s_cycle%0d", tag, k), 64'(capCycle[q+k]), 64'(cyc0 + k));
      end
    end
  endtask

  initial begin
    int st, st2, c1, c2, cRaise, readyCycle, errBase;

    sched.s_valid  = 1'b0;
    sched.s_data   = '0;
    sched.s_last   = 1'b0;
    sched.start_en = 1'b1;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_s_ready",    64'(sched.s_ready),    64'd1);
    checkOutput("rst_m_valid",    64'(sched.m_valid),    64'd0);
    checkOutput("rst_m_data",     64'(sched.m_data),     64'd0);
    checkOutput("rst_wave_start", 64'(sched.wave_start), 64'd0);
    checkOutput("rst_busy",       64'(sched.busy),       64'd0);
    checkOutput("rst_err_last",   64'(sched.err_last),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] full wave 0..23");
    clearCapture();
    applyStimulus(0, 24, -1, st, c1);
    checkOutput("t1_stalls", 64'(st), 64'd0);
    repeat (12) @(negedge clk);
    checkOutput("t1_count", 64'(capValid.size()), 64'd8);
    checkWave("t1", 0, 0, 8, 16, 3'b111, c1 + 1);
    checkOutput("t1_busy_after", 64'(sched.busy), 64'd0);

    $display("[TB] continuous 48 samples");
    clearCapture();
    applyStimulus(1, 24, -1, st, c1);
    applyStimulus(25, 24, -1, st2, c2);
    checkOutput("t2_stalls", 64'(st + st2), 64'd0);
    repeat (12) @(negedge clk);
    checkOutput("t2_count", 64'(capValid.size()), 64'd16);
    checkWave("t2a", 0, 1, 9, 17, 3'b111, c1 + 1);
    checkWave("t2b", 8, 25, 33, 41, 3'b111, c2 + 1);

    $display("[TB] start_en hold, both banks full, back-to-back release");
    clearCapture();
    sched.start_en = 1'b0;
    applyStimulus(1, 48, -1, st, c1);
    checkOutput("t3_fill_stalls", 64'(st), 64'd0);
    checkOutput("t3_ready_low", 64'(sched.s_ready), 64'd0);
    checkOutput("t3_busy_full", 64'(sched.busy), 64'd1);
    sched.s_valid = 1'b1;
    sched.s_data  = DW'(49);
    repeat (4) @(negedge clk);
    checkOutput("t3_ready_held", 64'(sched.s_ready), 64'd0);
    checkOutput("t3_no_wave", 64'(capValid.size()), 64'd0);
    sched.start_en = 1'b1;
    cRaise     = cycle;
    readyCycle = -1;
    for (int i = 0; i < 20 && readyCycle < 0; i++) begin
      @(negedge clk);
      if (sched.s_ready) readyCycle = cycle;
    end
    checkOutput("t3_ready_return", 64'(readyCycle), 64'(cRaise + 8));
    applyStimulus(49, 12, -1, st, c2);
    checkOutput("t3_tail_stalls", 64'(st), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("t3_count", 64'(capValid.size()), 64'd16);
    checkWave("t3a", 0, 1, 9, 17, 3'b111, cRaise + 1);
    checkWave("t3b", 8, 25, 33, 41, 3'b111, cRaise + 9);
    checkOutput("t3_busy_partial", 64'(sched.busy), 64'd0);
    resetDut();

    $display("[TB] short wave closed by s_last");
    clearCapture();
    errBase = errHigh;
    applyStimulus(100, 16, 15, st, c1);
    repeat (12) @(negedge clk);
    checkOutput("t4_count", 64'(capValid.size()), 64'd8);
    checkWave("t4", 0, 100, 108, 0, 3'b011, c1 + 1);
    checkOutput("t4_no_err", 64'(errHigh - errBase), 64'd0);

    $display("[TB] s_last mid-vector");
    clearCapture();
    errBase = errHigh;
    applyStimulus(200, 24, 4, st, c1);
    repeat (12) @(negedge clk);
    checkOutput("t5_err_pulses", 64'(errHigh - errBase), 64'd1);
    checkOutput("t5_count", 64'(capValid.size()), 64'd8);
    checkWave("t5", 0, 200, 208, 216, 3'b111, c1 + 1);

    $display("[TB] reset during an issuing wave");
    clearCapture();
    applyStimulus(300, 24, -1, st, c1);
    repeat (4) @(negedge clk);
    checkOutput("t6_pre_valid", 64'(sched.m_valid), 64'h7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_m_valid",    64'(sched.m_valid),    64'd0);
    checkOutput("t6_rst_m_data",     64'(sched.m_data),     64'd0);
    checkOutput("t6_rst_s_ready",    64'(sched.s_ready),    64'd1);
    checkOutput("t6_rst_busy",       64'(sched.busy),       64'd0);
    checkOutput("t6_rst_wave_start", 64'(sched.wave_start), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_partial_count", 64'(capValid.size()), 64'd4);
    clearCapture();
    applyStimulus(400, 24, -1, st, c1);
    repeat (12) @(negedge clk);
    checkOutput("t6_count", 64'(capValid.size()), 64'd8);
    checkWave("t6", 0, 400, 408, 416, 3'b111, c1 + 1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/dct_wave_scheduler.md
Name: dct_wave_scheduler

Overview:
- Sits in front of the Dct row-array. Collects a serial stream of 8-sample vectors and launches them as aligned "waves" across ROW DCT lanes.
- Each wave presents one vector per lane, all lanes driven on the same cycles. The Dct's internal per-lane skew stays consistent, and its modulo-8 phase counters never drift.
- Uses ping-pong buffering so one bank fills while the other issues. Back-to-back waves run with no bubble.

Parameters:
- DATA_WIDTH, 10, sample width in bits.
- ROW, 3, number of DCT lanes, which is the number of vectors per wave.
- N, 8, samples per vector; must be a power of two ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready; a sample transfers when s_valid & s_ready
- s_data  in  DATA_WIDTH  input sample
- s_last  in  1  end of frame, qualified with the handshake; closes the current bank early
- start_en  in  1  permits wave launch; low holds waves (frame-sync gating)
- m_data  out  ROW*DATA_WIDTH  lane r occupies bits [r*DATA_WIDTH +: DATA_WIDTH]
- m_valid  out  ROW  per-lane valid, feeds Dct in[r].valid
- wave_start  out  1  pulse coincident with word 0 of each wave
- busy  out  1  high in ISSUE or when any bank is full
- err_last  out  1  one-cycle pulse: s_last accepted at wr_idx != N-1

Behaviour:
- Storage is 2 banks × ROW × N words, with per-bank flags full[b] and lanes_used[b] (1..ROW).
- Write side:
  - State: wr_bank, wr_lane, wr_idx. A sample is written to bank[wr_bank][wr_lane][wr_idx].
  - wr_idx increments each transfer and wraps at N-1. At the wrap, wr_lane increments.
  - The bank closes on a transfer with wr_idx==N-1 when either wr_lane==ROW-1 or s_last==1. On close: full[wr_bank]<=1, lanes_used<=wr_lane+1, wr_bank toggles, wr_lane/wr_idx<=0.
  - s_last with wr_idx!=N-1: the sample is stored normally, err_last pulses, and the bank does not close.
  - s_ready = !full[wr_bank], from registered state only (no combinational path from s_valid).
- Read FSM states are IDLE and ISSUE, with counter rd_idx (log2 N bits) and rd_bank.
  - IDLE→ISSUE when full[rd_bank] & start_en. At that edge rd_idx<=0 and the outputs load word 0.
  - ISSUE: each edge loads m_data lane r = bank[rd_bank][r][rd_idx]. m_valid[r] = (r < lanes_used[rd_bank]). Unused lanes have m_valid=0 and m_data=0.
  - The edge that loads word N-1 also clears full[rd_bank] and toggles rd_bank.
  - On the following edge: if full[new rd_bank] & start_en, load word 0 of the next wave (no gap, wave_start=1). Otherwise go to IDLE and clear m_valid.
  - start_en is sampled only at wave boundaries. Deasserting it mid-wave never truncates a wave.
- Outputs (m_data, m_valid, wave_start) are registered. The path is fixed at 8 cycles of m_valid per wave, with exactly N cycles per wave.
- Latency: a bank closing at edge T gives word 0 visible after edge T+1 (start_en high, FSM idle).
- Same bank released and written in one cycle: impossible, because s_ready uses the pre-edge full flag. The bank is writable the cycle after release.
- Reset values: s_ready=1, m_valid=0, m_data=0, wave_start=0, busy=0, err_last=0, all flags/pointers 0, FSM=IDLE. Reset mid-operation discards partial banks and in-flight waves; no output glitch beyond the immediate clear.

Optional Feature:
- DCT_SCHED_ZERO_PAD_EN defined: unused lanes of a short wave drive m_valid=1 with m_data=0. All ROW lanes stay phase-aligned, and downstream sees zero-vectors.
- Undefined: unused lanes drive m_valid=0 (default behaviour above).

Test Plan:
- Full wave: ROW=3, N=8, start_en=1, 24 samples 0..23 back-to-back → after 2 cycles, 8 cycles of m_valid=3'b111 with lane0=0..7, lane1=8..15, lane2=16..23; wave_start only on word 0.
- Continuous 48 samples (1..48) → two waves with m_valid high 16 consecutive cycles, no bubble, s_ready never low.
- start_en=0, stream 60 samples → s_ready drops after sample 48 (both banks full). Raise start_en → waves 1..24, then 25..48; s_ready returns the cycle after the first release; samples 49..60 accepted afterward.
- Short wave: 16 samples, s_last on sample 16 → m_valid=3'b011 for 8 cycles and lane2 data=0. With DCT_SCHED_ZERO_PAD_EN → m_valid=3'b111, lane2=0.
- s_last on the 5th sample of a vector → err_last single pulse, no close; the bank closes normally after sample 24.
- rst_n asserted during cycle 4 of an issuing wave → m_valid=0 immediately, s_ready=1. A subsequent 24-sample stream produces a clean wave from lane0=new sample 0.
